// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM access sequencer: FSM state encoding and command codes.
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_FILL,
        ST_FILLV,
        ST_RSP
    } state_t;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_FILL  = 2'b10;

endpackage

// File: rtl/ram_addr_sweep.sv
// Address sweep counter for fill and fill-verify passes; wraps modulo 2^ADDR_W.
module ram_addr_sweep #(
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + ADDR_W'(1);
    end

    assign last = (cnt == {ADDR_W{1'b1}});

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response sequencer in front of a small single-port RAM.
// Optional VERIFY_EN: read back every write and fill, flag mismatches on rsp_err.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 8
) (
    input  logic              CLK_,
    input  logic              CLR,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              ram_r_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t              state;
    logic                r_w_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   cnt;
    logic                cnt_last;
`ifdef VERIFY_EN
    logic                wr_chk_q;
`endif

    // Reset overrides the registered strobe so a reset cycle can never write the RAM.
    assign ram_r_w = r_w_q | CLR;

    ram_addr_sweep #(.ADDR_W(ADDR_W)) u_sweep (
        .clk  (CLK_),
        .rst  (CLR),
        .clr  (state == ST_IDLE),
        .inc  ((state == ST_FILL) || (state == ST_FILLV)),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge CLK_) begin
        if (CLR) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            r_w_q     <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef VERIFY_EN
            wr_chk_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        data_q    <= req_data;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_err   <= 1'b0;
`ifdef VERIFY_EN
                        wr_chk_q  <= (req_cmd == CMD_WRITE);
`endif
                        case (req_cmd)
                            CMD_READ: begin
                                state    <= ST_RD;
                                ram_addr <= req_addr;
                            end
                            CMD_WRITE: begin
                                state     <= ST_WR;
                                r_w_q     <= 1'b0;
                                ram_addr  <= req_addr;
                                ram_wdata <= req_data;
                            end
                            CMD_FILL: begin
                                state     <= ST_FILL;
                                r_w_q     <= 1'b0;
                                ram_addr  <= '0;
                                ram_wdata <= req_data;
                            end
                            default: begin
                                state     <= ST_RSP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= '0;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_WR: begin
                    r_w_q     <= 1'b1;
                    ram_wdata <= '0;
`ifdef VERIFY_EN
                    // Address stays put: the read-back targets the word just written.
                    state     <= ST_RD;
`else
                    state     <= ST_RSP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= data_q;
                    ram_addr  <= '0;
`endif
                end

                ST_RD: begin
                    rsp_data  <= ram_rdata;
`ifdef VERIFY_EN
                    if (wr_chk_q && (ram_rdata != data_q))
                        rsp_err <= 1'b1;
`endif
                    state     <= ST_RSP;
                    rsp_valid <= 1'b1;
                    ram_addr  <= '0;
                end

                ST_FILL: begin
                    if (cnt_last) begin
                        r_w_q     <= 1'b1;
                        ram_wdata <= '0;
                        ram_addr  <= '0;
`ifdef VERIFY_EN
                        state     <= ST_FILLV;
`else
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= data_q;
`endif
                    end else begin
                        ram_addr  <= cnt + ADDR_W'(1);
                    end
                end

                ST_FILLV: begin
                    if (ram_rdata != data_q)
                        rsp_err <= 1'b1;
                    if (cnt_last) begin
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= data_q;
                        ram_addr  <= '0;
                    end else begin
                        ram_addr  <= cnt + ADDR_W'(1);
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_w_q     <= 1'b1;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural RAM and reference model.
module tb_ram_access_ctrl;

    localparam int D = 2;

    logic       CLK_ = 1'b0;
    logic       CLR = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_cmd = 2'b00;
    logic       req_addr = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       ram_r_w;
    logic       ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [0:1] = '{8'h00, 8'h00};
    logic       stuck0 = 1'b0;
    logic       bp_hold = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         at;
    } exp_t;
    exp_t exp_q[$];
    logic [7:0] ref_mem [0:1] = '{8'h00, 8'h00};

    ram_access_ctrl #(.ADDR_W(1), .DATA_W(8)) dut (
        .CLK_(CLK_), .CLR(CLR),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .ram_r_w(ram_r_w), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial forever #5 CLK_ = ~CLK_;

    always @(posedge CLK_) begin
        cyc <= cyc + 1;
        if (!ram_r_w) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr] | {7'b0, stuck0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Consumer side: random ready, or held low while a test asks for backpressure.
    initial forever begin
        @(posedge CLK_);
        #1;
        rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops one expectation per response and checks it while it is held.
    initial begin
        exp_t cur;
        bit   in_rsp = 0;
        forever begin
            @(negedge CLK_);
            if (CLR) begin
                chk("rst_r_w", ram_r_w, 1);
                in_rsp = 0;
                continue;
            end
            if (rsp_valid) begin
                chk("rsp_req_ready", req_ready, 0);
                chk("rsp_ram_r_w", ram_r_w, 1);
                chk("rsp_ram_addr", ram_addr, 0);
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        bound_fail("unexpected_rsp");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_data", rsp_data, cur.d);
                        chk("rsp_err", rsp_err, cur.e);
                        chk("rsp_latency", cyc, cur.at);
                        in_rsp = 1;
                    end
                end else begin
                    chk("hold_data", rsp_data, cur.d);
                    chk("hold_err", rsp_err, cur.e);
                end
                if (rsp_ready) in_rsp = 0;
            end else if (req_ready) begin
                chk("idle_busy", busy, 0);
                chk("idle_r_w", ram_r_w, 1);
                chk("idle_addr", ram_addr, 0);
                chk("idle_wdata", ram_wdata, 0);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int w = 0;
        @(negedge CLK_);
        while (!req_ready && w < 100) begin
            @(negedge CLK_);
            w++;
        end
        ok = req_ready;
        if (!ok) bound_fail("req_ready_wait");
    endtask

    // Issues one command and pushes the response the RAM rules predict.
    task automatic issue(input logic [1:0] c, input logic a, input logic [7:0] d);
        bit   ok;
        exp_t e;
        int   delta;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1; req_cmd = c; req_addr = a; req_data = d;
        @(posedge CLK_);
        #1;
        req_valid = 1'b0;
        case (c)
            2'b00: begin
                e.d = ref_mem[a] | {7'b0, stuck0}; e.e = 1'b0; delta = 1;
            end
            2'b01: begin
                ref_mem[a] = d;
`ifdef VERIFY_EN
                e.d = ref_mem[a] | {7'b0, stuck0}; e.e = (e.d != d); delta = 2;
`else
                e.d = d; e.e = 1'b0; delta = 1;
`endif
            end
            2'b10: begin
                e.e = 1'b0;
                for (int i = 0; i < D; i++) begin
                    ref_mem[i] = d;
`ifdef VERIFY_EN
                    if ((ref_mem[i] | {7'b0, stuck0}) != d) e.e = 1'b1;
`endif
                end
                e.d = d;
`ifdef VERIFY_EN
                delta = 2 * D;
`else
                delta = D;
`endif
            end
            default: begin
                e.d = 8'h00; e.e = 1'b1; delta = 0;
            end
        endcase
        e.at = cyc + delta;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge CLK_);
            w++;
        end
        if (exp_q.size() != 0) bound_fail("drain");
    endtask

    initial begin
        bit ok;
        int w;
        // Reset with a write offered: nothing may reach the RAM.
        req_valid = 1'b1; req_cmd = 2'b01; req_addr = 1'b1; req_data = 8'hEE;
        repeat (2) @(posedge CLK_);
        #1;
        CLR = 1'b0; req_valid = 1'b0;
        @(negedge CLK_);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_data", rsp_data, 0);
        chk("post_rst_err", rsp_err, 0);
        chk("post_rst_mem1", mem[1], 0);

        issue(2'b01, 1'b1, 8'hA5);
        issue(2'b00, 1'b1, 8'h00);
        issue(2'b10, 1'b0, 8'h3C);
        issue(2'b00, 1'b0, 8'h00);
        issue(2'b00, 1'b1, 8'h00);
        issue(2'b11, 1'b1, 8'h5A);
        drain();

        // Backpressure: response must hold for three cycles with ready low.
        bp_hold = 1'b1;
        issue(2'b00, 1'b0, 8'h00);
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(negedge CLK_);
            w++;
        end
        if (!rsp_valid) bound_fail("bp_rsp_wait");
        repeat (3) @(posedge CLK_);
        #1;
        bp_hold = 1'b0;
        drain();

`ifdef VERIFY_EN
        stuck0 = 1'b1;
        issue(2'b01, 1'b0, 8'hFE);
        drain();
        wait_ready(ok);
        stuck0 = 1'b0;
`endif

        // Reset in the second fill cycle: only address 0 gets the fill word.
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1; req_cmd = 2'b10; req_addr = 1'b0; req_data = 8'h77;
            @(posedge CLK_);
            #1;
            req_valid = 1'b0;
            @(posedge CLK_);
            #1;
            CLR = 1'b1;
            @(posedge CLK_);
            #1;
            CLR = 1'b0;
            ref_mem[0] = 8'h77;
            chk("clr_mid_fill_state", {busy, req_ready, rsp_valid}, 3'b010);
        end
        issue(2'b00, 1'b0, 8'h00);
        issue(2'b00, 1'b1, 8'h00);
        drain();

        for (int n = 0; n < 80; n++) begin
            int r;
            logic [1:0] c;
            r = $urandom_range(0, 9);
            c = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            issue(c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        drain();
        repeat (4) @(posedge CLK_);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator-side sequencer for the 1-bit-address, 8-bit-wide RAM. Accepts read, write and fill commands on a valid/ready request port. Drives the RAM's read/write, address and write-data inputs, and samples its read data. Returns one response per command on a valid/ready response port, so the rest of the design never toggles the RAM control lines directly.

## Interface
Parameters:
- ADDR_W, 1, RAM address width; depth D = 2^ADDR_W
- DATA_W, 8, RAM word width

Ports (one clock; reset is synchronous and active-high):
- CLK_  in  1  clock, shared with the RAM
- CLR  in  1  synchronous active-high reset
- req_valid  in  1  command offered
- req_ready  out  1  controller can accept a command
- req_cmd  in  2  00 read, 01 write, 10 fill, 11 illegal
- req_addr  in  ADDR_W  target address (ignored for fill)
- req_data  in  DATA_W  write/fill data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  response word
- rsp_err  out  1  verify mismatch or illegal command
- busy  out  1  state != IDLE
- ram_r_w  out  1  to RAM R_W_: 1 read, 0 write
- ram_addr  out  ADDR_W  to RAM ADDR_
- ram_wdata  out  DATA_W  to RAM data_in
- ram_rdata  in  DATA_W  from RAM data_out, combinational read of ram_addr

## Operation
- States: IDLE, WR, RD, FILL, FILLV, RSP.
- IDLE: req_ready=1. On req_valid&&req_ready the controller latches cmd, addr and data.
  - read -> RD; write -> WR; fill -> FILL with sweep counter=0; illegal -> RSP.
- WR: drives ram_r_w=0, latched addr and data. The RAM writes at this cycle's edge.
  - Next state is RSP, or RD when VERIFY_EN is defined.
- RD: drives ram_r_w=1 and the addr. ram_rdata is captured into rsp_data at the edge, then -> RSP.
  - With VERIFY_EN after a write, rsp_err is set on any mismatch against the latched data.
- FILL: each cycle writes the latched data at ram_addr=counter and increments the counter.
  - When counter == D-1, the counter wraps to 0 and the state goes to FILLV (VERIFY_EN) or RSP.
- FILLV: reads at the counter address and compares; any mismatch sets rsp_err (sticky for the command). At D-1 -> RSP.
- RSP: rsp_valid=1, with rsp_data and rsp_err held stable until rsp_ready. On the rsp_valid&&rsp_ready edge -> IDLE.
- rsp_data by command:
  - read: the word read.
  - write: the latched data, or the read-back word with VERIFY_EN.
  - fill: the latched data.
  - illegal: 0, with rsp_err=1.
- Outside WR/FILL, ram_r_w=1. ram_addr and ram_wdata are 0 in IDLE/RSP.
- All address arithmetic is modulo D; the counter is ADDR_W bits.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, ram_r_w=1, ram_addr=0, ram_wdata=0.
- While CLR is high:
  - ram_r_w is forced to 1, so no RAM write happens in a reset cycle.
  - Requests are ignored.
- CLR mid-operation: the next state is IDLE and the pending response is dropped. RAM contents written before the reset cycle persist. The controller never drives the RAM's own CLR.
- Command accepted at edge N; rsp_valid rises in the cycle after the last access cycle:
  - read: RD in cycle N+1, rsp_valid in N+2.
  - write: WR in N+1, rsp_valid in N+2. With VERIFY_EN, RD in N+2 and rsp_valid in N+3.
  - fill: FILL in N+1..N+D, rsp_valid in N+D+1. VERIFY_EN adds D FILLV cycles.
  - illegal: rsp_valid in N+1.
- req_ready is low from the acceptance edge until the state returns to IDLE. No new command is taken in the response-handshake cycle; minimum spacing between accepts is latency+1.
- A rsp_ready held high before rsp_valid completes the handshake in rsp_valid's first cycle.

## Configuration
- VERIFY_EN defined:
  - A write is followed by one read-back cycle.
  - A fill is followed by a D-cycle read-back sweep.
  - Mismatches set rsp_err.
- VERIFY_EN undefined:
  - FILLV and the post-write RD are absent.
  - rsp_err is only set by an illegal command.

## Structure
- Shared package ram_ctrl_pkg holds the state enum and the command codes (CMD_READ=2'b00, CMD_WRITE=2'b01, CMD_FILL=2'b10).
- Sub-module ram_addr_sweep holds the ADDR_W-bit counter with clear, increment and last-flag (count == D-1). It is used by FILL and FILLV.

## Test plan
- Reset: CLR high 2 cycles with req_valid=1 -> no ram_r_w=0 pulse; after release req_ready=1, rsp_valid=0.
- Write addr 1 data 8'hA5, then read addr 1 -> rsp_valid at N+2 each; read returns 8'hA5, rsp_err=0. With VERIFY_EN the write response comes at N+3.
- Fill 8'h3C -> writes at addr 0 then 1, rsp_valid at N+3; reads of both addresses return 8'h3C.
- VERIFY_EN with the RAM model forcing data_out bit 0 stuck: write 8'hFE -> rsp_err=1, rsp_data=8'hFF.
- Illegal cmd 11 -> rsp_valid at N+1, rsp_err=1, rsp_data=0, ram_r_w stays 1.
- Backpressure and reset:
  - rsp_ready low for 3 cycles -> rsp_valid and rsp_data held, req_ready=0.
  - CLR asserted during FILL -> IDLE next cycle, no response.
